// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared state encoding and widths for the DAC sample scheduler
package dac_sched_pkg;
    localparam int SAMPLE_W = 16;
    localparam int ACT_W = 3;
    typedef enum logic [1:0] {IDLE, ARB, ISSUE} state_t;
endpackage

// File: rtl/dac_sample_scheduler_if.sv
// dac_sample_scheduler_if: source, DAC and diagnostic signals around the scheduler
interface dac_sample_scheduler_if
    import dac_sched_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int CNT_W = 16
);
    logic [SAMPLE_W*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0] src_valid;
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] src_enable;
    logic [SAMPLE_W-1:0] dac_data;
    logic dac_valid;
    logic dac_ready;
    logic tick;
    logic [ACT_W-1:0] active_src;
    logic [CNT_W-1:0] underrun_count;
    logic [CNT_W-1:0] late_count;
    modport slave (
        input src_data, src_valid, src_enable, dac_ready,
        output src_ready, dac_data, dac_valid, tick, active_src, underrun_count, late_count
    );
    modport master (
        output src_data, src_valid, src_enable, dac_ready,
        input src_ready, dac_data, dac_valid, tick, active_src, underrun_count, late_count
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting one past the previous grant
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     i_req,
    input  logic [ACT_W-1:0] i_prev,
    output logic [N-1:0]     o_gnt,
    output logic [ACT_W-1:0] o_idx,
    output logic             o_any
);
    int w_start;
    int w_off;
    int w_pick;
    logic [N-1:0] w_rot;
    // rotate so the highest-priority requester lands on bit 0
    always_comb begin
        w_start = (int'(i_prev) + 1) % N;
        w_rot = N'({i_req, i_req} >> w_start);
        w_off = 0;
        for (int k = N - 1; k >= 0; k--)
            if (w_rot[k]) w_off = k;
        w_pick = (w_start + w_off) % N;
        o_any = |i_req;
        o_idx = ACT_W'(w_pick);
        o_gnt = o_any ? N'(1) << w_pick : '0;
    end
endmodule

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: sample-rate pacer and round-robin source arbiter feeding the DAC driver
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DIV = 2500,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    dac_sample_scheduler_if.slave bus
);
    localparam int PW = $clog2(DIV);
    state_t r_state;
    logic [PW-1:0] r_cnt;
    logic [SAMPLE_W-1:0] r_data;
    logic [ACT_W-1:0] r_active;
    logic r_valid;
    logic [CNT_W-1:0] r_under;
    logic [CNT_W-1:0] r_late;
    logic w_tick;
    logic w_any;
    logic [NUM_SRC-1:0] w_req;
    logic [NUM_SRC-1:0] w_gnt;
    logic [ACT_W-1:0] w_idx;
    logic [SAMPLE_W-1:0] w_sel;
    assign w_tick = r_cnt == PW'(DIV - 1);
    assign w_req = bus.src_valid & bus.src_enable;
    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .i_req(w_req),
        .i_prev(r_active),
        .o_gnt(w_gnt),
        .o_idx(w_idx),
        .o_any(w_any)
    );
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (w_gnt[i]) w_sel = bus.src_data[i*SAMPLE_W +: SAMPLE_W];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_data <= '0;
            r_active <= ACT_W'(NUM_SRC - 1);
            r_valid <= 1'b0;
            r_under <= '0;
            r_late <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + PW'(1);
            // a tick arriving while a transfer is in flight is dropped, not queued
            if (w_tick && r_state != IDLE && r_late != '1) r_late <= r_late + CNT_W'(1);
            case (r_state)
                IDLE: if (w_tick) r_state <= ARB;
                ARB: begin
                    r_state <= ISSUE;
                    r_valid <= 1'b1;
                    if (bus.src_enable == '0) r_data <= '0;
                    else if (w_any) begin
                        r_data <= w_sel;
                        r_active <= w_idx;
                    end else if (r_under != '1) r_under <= r_under + CNT_W'(1);
                end
                ISSUE: if (bus.dac_ready) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.tick = w_tick;
    assign bus.src_ready = (r_state == ARB && !rst) ? w_gnt : '0;
    assign bus.dac_data = r_data;
    assign bus.dac_valid = r_valid;
    assign bus.active_src = r_active;
    assign bus.underrun_count = r_under;
    assign bus.late_count = r_late;
endmodule

// File: doc/dac_sample_scheduler.md
# dac_sample_scheduler

Sample-rate pacer and round-robin arbiter in front of the PMOD DA3 DAC driver. It generates a fixed sample-period tick from the system clock. On each tick it grants at most one of `NUM_SRC` sample sources and forwards one 16-bit sample to the driver's valid/ready input. It also covers underrun (repeat last sample), all-muted (output zero) and late-transfer (dropped tick) conditions, and exposes saturating diagnostic counters.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of requesters, 2..8.
- `DIV`, default 2500: clock cycles per sample period (100 MHz / 40 kHz). Minimum 4.
- `CNT_W`, default 16: width of the diagnostic counters.

Ports:
- `clk` input 1: system clock. This is the block's only clock.
- `rst` input 1: reset, synchronous, active-high.
- `src_data` input `16*NUM_SRC`: sample from source i on bits [16i+15:16i].
- `src_valid` input `NUM_SRC`: source i holds a sample. Held until accepted.
- `src_ready` output `NUM_SRC`: one-hot accept strobe. At most one bit is high, for one cycle.
- `src_enable` input `NUM_SRC`: per-source arbitration mask.
- `dac_data` output 16: sample to the DAC driver.
- `dac_valid` output 1: sample offered to the driver.
- `dac_ready` input 1: driver accepts the sample.
- `tick` output 1: one-cycle pulse at each sample-period boundary.
- `active_src` output 3: index of the last granted source.
- `underrun_count` output `CNT_W`: count of ticks with no enabled source valid. Saturating.
- `late_count` output `CNT_W`: count of ticks dropped because the previous transfer was still pending. Saturating.

## Operation
- Period counter runs 0..DIV-1 and wraps. `tick` is high while the count equals DIV-1. The counter never stalls.
- State machine has three states: IDLE, ARB, ISSUE.
- **IDLE → ARB** when `tick` is high.
- **ARB** lasts one cycle. Request vector is `src_valid & src_enable`. Round-robin search starts at `active_src+1` and wraps modulo `NUM_SRC`. Three outcomes:
  - **Grant g:** `src_ready[g]`=1 this cycle. Combinational from state and `src_valid`; never depends on `src_ready`. Capture `src_data[g]` into `dac_data`. Set `active_src`=g.
  - **No request, `src_enable`≠0:** underrun. `dac_data` keeps its previous value. `underrun_count`+1.
  - **`src_enable`=0:** mute. `dac_data`=0. No counter change.
  - In all three cases → ISSUE.
- **ISSUE:**
  - `dac_valid`=1 and `dac_data` held stable until the cycle where `dac_valid & dac_ready`.
  - After that handshake → IDLE, and `dac_valid`=0 on the next cycle.
- **Tick while in ARB or ISSUE:** `late_count`+1. The tick is dropped, not queued. The current transfer continues unchanged.
- **Tick in the same cycle as the ISSUE handshake:** counts as late. The block still returns to IDLE and waits for the following tick.
- Both counters saturate at all-ones and clear only on `rst`.
- `src_enable` and `src_valid` are sampled only in ARB. Changes at any other time have no effect until the next ARB.

## Timing
- Reset values:
  - state IDLE, period count 0, `tick` 0.
  - `src_ready` 0, `dac_valid` 0, `dac_data` 0.
  - `active_src`=NUM_SRC-1, so the first grant priority is source 0.
  - both counters 0.
- `rst` asserted mid-transfer: `dac_valid` is low on the cycle after the `rst` edge. No `src_ready` pulse occurs during reset.
- Latency for tick in cycle T:
  - ARB (and any `src_ready` pulse) in cycle T+1.
  - `dac_valid` first high in cycle T+2.
  - With `dac_ready` held high, `dac_valid` is high for exactly one cycle.
- Exactly one DAC transfer per accepted tick. At most one `src_ready` pulse per period.
- First tick occurs DIV cycles after reset is released (count DIV-1).

## Structure
- Package `dac_sched_pkg` holds:
  - state encoding (IDLE/ARB/ISSUE);
  - sample width constant SAMPLE_W=16;
  - `active_src` width constant 3.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs: request vector, previous-grant index;
  - outputs: grant one-hot, grant index, `any`;
  - purely combinational.
- Top level holds the period counter, FSM, data register and counters.

## Test plan
- Reset, DIV=8, sources 0 and 2 valid and enabled, `dac_ready`=1:
  - ticks at cycles 7, 15, 23;
  - grants alternate 0, 2, 0;
  - `dac_valid` at cycles 9, 17, 25.
- Source 1 only, data 0x1234, then `src_valid` dropped:
  - first period outputs 0x1234;
  - next two periods output 0x1234 again;
  - `underrun_count`=2.
- `src_enable`=0 with all sources valid:
  - `dac_data`=0 every period;
  - no `src_ready` pulse;
  - `underrun_count` unchanged.
- `dac_ready` held low for 3·DIV cycles:
  - `late_count`=3;
  - `dac_data` stable throughout;
  - after `dac_ready` rises, one handshake, then the next grant at the following tick.
- `rst` asserted while `dac_valid`=1:
  - next cycle `dac_valid`=0, counters 0, `active_src`=NUM_SRC-1;
  - first post-reset tick after DIV cycles grants source 0.
- Force `late_count` to all-ones via a long stall: it stays all-ones on further late ticks.
